sda_arbiter: RTL and testbench
==============================

# sda_arbiter

Round-robin arbiter and transfer sequencer that shares the single parallel-to-serial SDA/SCL transmitter between four nibble producers. It selects a requester, latches its 4-bit word, presents it on the serializer's data input, follows the serializer's `ack` handshake to completion, and reports completion or timeout back to the requester. It sits directly upstream of the serializer, in the same `sclk` domain.

## Interface
- `N`, 4: number of requesters; fixed at 4 in this release.
- `W`, 4: nibble width; must equal the serializer data width.
- `TIMEOUT`, 255: maximum cycles spent waiting on `ser_ack` per phase; range 1 to 2^`CNT_W`-1.
- `CNT_W`, 8: timeout counter width.

Ports:
- `sclk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N: per-requester transfer request; level, held until `done` or `timeout_err`.
- `req_data` in N*W: requester i's word in bits [i*W +: W].
- `gnt` out N: one-hot grant; high from latch until the end of the transfer.
- `done` out N: one-hot, one-cycle pulse on successful completion.
- `ser_data` out W: word presented to the serializer `data` input.
- `ser_ack` in 1: serializer `ack`; 1 = ready to take a word, 1→0 = word taken.
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: one-cycle pulse when a transfer is abandoned.

## Operation
- States and transitions:
  - IDLE: if any `req`, go to WAIT_RDY.
  - WAIT_RDY: if `ser_ack`=1, go to WAIT_TAKE.
  - WAIT_TAKE: if `ser_ack`=0, go to DONE.
  - DONE: return to IDLE.
- Arbitration in IDLE:
  - Search `req` starting at pointer `ptr` (2 bits), wrapping 3→0; the first set bit wins.
  - On a win, register the index, latch `req_data` slice into the hold register, and set `gnt[idx]`.
- `ser_data` = hold register from entry to WAIT_RDY until return to IDLE. It does not change during a transfer.
- Requesters may change `req_data` once `gnt` is seen. Dropping `req` mid-transfer is ignored; the transfer completes.
- DONE: pulse `done[idx]`, clear `gnt`, set `ptr` = idx+1 (mod 4).
- Timeout:
  - The counter clears on entry to WAIT_RDY and again on entry to WAIT_TAKE.
  - It increments each cycle in those two states.
  - When it reaches `TIMEOUT` before the exit condition, pulse `timeout_err`, clear `gnt`, go to IDLE, set `ptr` = idx+1. No `done` pulse.
- If `ser_ack` is already 1 on entry to WAIT_RDY, the state is left after one cycle.
- A glitch-free 1→0 on `ser_ack` in WAIT_RDY has no effect.
- `ser_ack` is driven by the serializer on the falling edge and is sampled here on the rising edge without synchronizers.

## Timing
- Reset values: `gnt`=0, `done`=0, `ser_data`=0, `busy`=0, `timeout_err`=0, `ptr`=0, state IDLE, counter 0.
- Reset mid-transfer aborts immediately; no `done` or `timeout_err` is issued.
- Latency:
  - `req` sampled high in IDLE → `gnt` and `ser_data` valid the next cycle.
  - `ser_ack` falling sampled in WAIT_TAKE → `done` one cycle later (DONE state).
- Minimum transfer is 4 cycles (IDLE, WAIT_RDY, WAIT_TAKE, DONE); back-to-back grants are separated by one IDLE cycle.
- Simultaneous requests: only the winner is granted. Losers keep `req` high and are served in rotation, so no requester waits more than 3 transfers.
- New `req` edges during a transfer are not seen until IDLE.
- `done` and `timeout_err` are never high in the same cycle.

## Structure
- Shared package holds:
  - state encoding, localparams `ST_IDLE`=2'd0, `ST_WAIT_RDY`=2'd1, `ST_WAIT_TAKE`=2'd2, `ST_DONE`=2'd3;
  - default `TIMEOUT` and `CNT_W`;
  - nibble width constant, shared with the serializer.
- One sub-module, `rr_pick4`: combinational round-robin priority search (`req`, `ptr` → `valid`, `idx`).
- FSM, hold register, and timeout counter live in the top.

## Test plan
- Single request: `req`=0001, data 4'hA. Serializer model raises ack 2 cycles later and drops it 6 cycles after that. Expect `gnt`=0001 next cycle, `ser_data`=A until completion, `done`=0001 for one cycle, `ptr`=1.
- All requesting: `req`=1111 with data 1,2,3,4, serializer cooperating. Expect grant order 0,1,2,3, each word appearing on `ser_data` in that order, four `done` pulses.
- Rotation from `ptr`=2 with `req`=0101: expect requester 2 first, then 0.
- Stuck serializer: `ser_ack` held 0 with `TIMEOUT`=8. Expect `timeout_err` pulse 8 cycles after WAIT_RDY entry, `gnt` cleared, no `done`, next requester granted.
- Requester changes `req_data` from 5 to C after `gnt` and drops `req`: expect `ser_data` stays 5 and `done` still pulses.
- `rst` asserted in WAIT_TAKE: expect all outputs 0 next cycle and `ptr`=0. After release, a pending `req`=1000 is granted normally.

Source files
------------

// File: rtl/sda_arbiter_pkg.sv
// Shared definitions for the SDA/SCL transmitter arbiter.
// Holds the sequencer state encoding, default timeout settings and the
// nibble width that the arbiter shares with the serializer.
package sda_arbiter_pkg;

  // Nibble width; the serializer data input uses the same constant.
  localparam int unsigned NIB_W = 4;

  // Number of requesters handled by this release.
  localparam int unsigned N_REQ = 4;

  // Default timeout, in cycles, for each wait phase, and the counter width.
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W_DEF   = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WAIT_RDY  = 2'd1;
  localparam state_t ST_WAIT_TAKE = 2'd2;
  localparam state_t ST_DONE      = 2'd3;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin priority search over four requesters.
// Ports:
//   req_i   - request vector
//   ptr_i   - index searched first; the search wraps 3 -> 0
//   valid_o - at least one request is set
//   idx_o   - index of the first set request at or after ptr_i
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand;

  // Walk from the farthest position back to ptr_i so the nearest set bit
  // is the last one written and therefore wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = ptr_i;
    cand    = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/sda_arbiter.sv
// Round-robin arbiter and transfer sequencer in front of the SDA/SCL
// serializer. Picks one of four nibble producers, holds its word on
// ser_data, follows the serializer ack handshake and reports done or
// timeout back.
// Ports:
//   sclk, rst    - clock and synchronous active-high reset
//   req          - per-requester level request
//   req_data     - requester i's word in bits [i*W +: W]
//   gnt          - one-hot grant while waiting on the serializer
//   done         - one-hot completion pulse
//   ser_data     - word presented to the serializer
//   ser_ack      - serializer ack (1 = ready, 1->0 = word taken)
//   busy         - sequencer not idle
//   timeout_err  - pulse when a transfer is abandoned
module sda_arbiter
  import sda_arbiter_pkg::*;
#(
  parameter int unsigned N       = N_REQ,
  parameter int unsigned W       = NIB_W,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic           sclk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   ser_data,
  input  logic           ser_ack,
  output logic           busy,
  output logic           timeout_err
);

  // Counter value seen on the last cycle a phase may wait.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [W-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [W-1:0]     pick_word;
  logic             cnt_last;

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign cnt_last = (cnt_q == CntLast);

  // State register and datapath registers.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    to_d      = 1'b0;
    pick_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_idx == 2'(i)) begin
        pick_word = req_data[i*W +: W];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_WAIT_RDY;
          idx_d   = pick_idx;
          hold_d  = pick_word;
          cnt_d   = '0;
        end
      end
      ST_WAIT_RDY: begin
        if (ser_ack) begin
          state_d = ST_WAIT_TAKE;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = ST_IDLE;
          to_d    = 1'b1;
          ptr_d   = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_TAKE: begin
        if (!ser_ack) begin
          state_d = ST_DONE;
        end else if (cnt_last) begin
          state_d = ST_IDLE;
          to_d    = 1'b1;
          ptr_d   = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = idx_q + 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. The grant is dropped in DONE so it never overlaps done.
  always_comb begin
    gnt         = '0;
    done        = '0;
    busy        = (state_q != ST_IDLE);
    ser_data    = busy ? hold_q : '0;
    timeout_err = to_q;
    if (state_q == ST_WAIT_RDY || state_q == ST_WAIT_TAKE) begin
      gnt[idx_q] = 1'b1;
    end
    if (state_q == ST_DONE) begin
      done[idx_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_sda_arbiter.sv
// Self-checking bench for sda_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle with a behavioural model.
module tb_sda_arbiter;

  localparam int TO = 8;

  logic        sclk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  ser_data;
  logic        ser_ack;
  logic        busy;
  logic        timeout_err;

  always #5 sclk = ~sclk;

  sda_arbiter #(
    .N       (4),
    .W       (4),
    .TIMEOUT (TO),
    .CNT_W   (8)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .ser_data    (ser_data),
    .ser_ack     (ser_ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model of one transfer: phase 0 idle, 1 waiting for ready, 2 waiting for
  // the word to be taken, 3 reporting completion.
  int m_phase, m_idx, m_hold, m_wait, m_ptr;
  bit m_to;

  // Bench-side serializer behaviour and requester bookkeeping.
  bit auto_ack   = 0;
  bit auto_clear = 1;
  int rdy_dly    = 0;
  int take_dly   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_idx = 0; m_hold = 0; m_wait = 0; m_ptr = 0; m_to = 0;
    end else begin
      m_to = 0;
      case (m_phase)
        0: begin
          for (int k = 0; k < 4; k++) begin
            automatic int c = (m_ptr + k) % 4;
            if (req[c]) begin
              m_phase = 1;
              m_idx   = c;
              m_hold  = (req_data >> (4 * c)) & 15;
              m_wait  = 0;
              break;
            end
          end
        end
        1, 2: begin
          if ((m_phase == 1) ? ser_ack : !ser_ack) begin
            m_phase = m_phase + 1;
            m_wait  = 0;
          end else if (m_wait + 1 >= TO) begin
            m_phase = 0;
            m_to    = 1;
            m_ptr   = (m_idx + 1) % 4;
          end else begin
            m_wait++;
          end
        end
        default: begin
          m_phase = 0;
          m_ptr   = (m_idx + 1) % 4;
        end
      endcase
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] e_gnt, e_done;
    e_gnt  = (m_phase == 1 || m_phase == 2) ? 4'(1 << m_idx) : 4'd0;
    e_done = (m_phase == 3) ? 4'(1 << m_idx) : 4'd0;
    check_eq("gnt", gnt, e_gnt);
    check_eq("done", done, e_done);
    check_eq("busy", busy, m_phase != 0);
    check_eq("ser_data", ser_data, (m_phase != 0) ? m_hold : 0);
    check_eq("timeout_err", timeout_err, m_to);
    check_eq("done_and_timeout", (|done) && timeout_err, 0);
  endtask

  task automatic drive_auto();
    if (auto_clear && (m_phase == 3 || m_to)) req[m_idx] = 1'b0;
    if (auto_ack) begin
      if (m_phase == 1)      ser_ack = (m_wait >= rdy_dly);
      else if (m_phase == 2) ser_ack = (m_wait < take_dly);
      else                   ser_ack = 1'b0;
    end
  endtask

  // One clock: model follows the rising edge, checks land on the falling edge.
  task automatic step();
    @(posedge sclk);
    model_step();
    @(negedge sclk);
    compare_outputs();
    drive_auto();
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp);
    int n = 0;
    while (done == 4'd0 && n < 40) begin
      step();
      n++;
    end
    check_eq(tag, done, exp);
  endtask

  initial begin
    int n;
    int stuck;
    rst = 1'b1; req = '0; req_data = '0; ser_ack = 1'b0;
    m_phase = 0; m_idx = 0; m_hold = 0; m_wait = 0; m_ptr = 0; m_to = 0;
    step();
    step();
    check_eq("reset_gnt", gnt, 4'd0);
    check_eq("reset_busy", busy, 1'b0);
    rst = 1'b0;

    // Single request, slow serializer.
    auto_ack = 1; rdy_dly = 2; take_dly = 6;
    req = 4'b0001; req_data = 16'h000A;
    step();
    check_eq("single_gnt", gnt, 4'b0001);
    check_eq("single_data", ser_data, 4'hA);
    wait_done("single_done", 4'b0001);
    check_eq("single_done_data", ser_data, 4'hA);
    step();

    // All requesting from ptr 0 with ack already high on entry.
    rst = 1'b1; step(); rst = 1'b0;
    rdy_dly = 0; take_dly = 2;
    req = 4'b1111; req_data = 16'h4321;
    for (int i = 0; i < 4; i++) begin
      wait_done("all_done", 4'(1 << i));
      check_eq("all_data", ser_data, i + 1);
      step();
    end

    // Rotation: serve requester 1 so the search starts at 2, then 0101.
    req = 4'b0010; req_data = 16'h0070;
    wait_done("rot_setup", 4'b0010);
    step();
    req = 4'b0101; req_data = 16'h0806;
    wait_done("rot_first", 4'b0100);
    check_eq("rot_first_data", ser_data, 4'h8);
    step();
    wait_done("rot_second", 4'b0001);
    check_eq("rot_second_data", ser_data, 4'h6);
    step();

    // Stuck serializer: search starts at 1, so requester 1 times out.
    auto_ack = 0; ser_ack = 1'b0;
    req = 4'b0011; req_data = 16'h00B9;
    step();
    check_eq("stuck_gnt", gnt, 4'b0010);
    n = 0;
    while (!timeout_err && n < 20) begin
      step();
      n++;
    end
    check_eq("stuck_cycles", n, TO);
    check_eq("stuck_gnt_clear", gnt, 4'd0);
    check_eq("stuck_no_done", done, 4'd0);
    step();
    check_eq("stuck_next_gnt", gnt, 4'b0001);
    auto_ack = 1; rdy_dly = 1; take_dly = 1;
    wait_done("stuck_next_done", 4'b0001);
    step();

    // Data and request change after grant are ignored.
    rdy_dly = 3; take_dly = 3;
    req = 4'b0100; req_data = 16'h0500;
    step();
    check_eq("chg_gnt", gnt, 4'b0100);
    req = 4'b0000; req_data = 16'h0C00;
    wait_done("chg_done", 4'b0100);
    check_eq("chg_data", ser_data, 4'h5);
    step();

    // Reset in WAIT_TAKE, then the still-pending request is served.
    rdy_dly = 0; take_dly = 5;
    req = 4'b1000; req_data = 16'hD000;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check_eq("rst_gnt", gnt, 4'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_data", ser_data, 4'd0);
    rst = 1'b0;
    step();
    check_eq("rst_regnt", gnt, 4'b1000);
    wait_done("rst_done", 4'b1000);
    step();

    // Randomized traffic.
    auto_ack = 0;
    stuck = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[i*4 +: 4] = 4'($urandom);
        end else if (req[i] && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
      if (m_phase != 0 && $urandom_range(0, 3) == 0) req_data[m_idx*4 +: 4] = 4'($urandom);
      if (stuck == 0 && $urandom_range(0, 99) == 0) stuck = 12;
      if (stuck > 0) begin
        ser_ack = 1'b0;
        stuck--;
      end else begin
        ser_ack = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
